// File: rtl/core_run_ctrl.sv
// core_run_ctrl: run-control sequencer for the single-cycle RV32 core.
// Generates the common core enable. Handles host run/halt/step commands and
// PC breakpoints. Stops the core on a breakpoint, ebreak or ecall before the
// stopping instruction executes.
module core_run_ctrl #(
   parameter int NUM_BP = 2,
   parameter int CNT_W  = 32,
   parameter int STEP_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [1:0]        cmd_idx,
   input  logic [31:0]       cmd_data,
   output logic              cmd_err,
   input  logic [31:0]       pc,
   input  logic [31:0]       instr,
   output logic              core_en,
   output logic              halted,
   output logic [2:0]        halt_cause,
   output logic [NUM_BP-1:0] bp_hit,
   output logic [CNT_W-1:0]  retired
);

   localparam logic [1:0] ST_HALTED = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_STEP   = 2'd2;

   localparam logic [2:0] OP_RUN     = 3'd0;
   localparam logic [2:0] OP_HALT    = 3'd1;
   localparam logic [2:0] OP_STEP    = 3'd2;
   localparam logic [2:0] OP_SET_BP  = 3'd3;
   localparam logic [2:0] OP_CLR_BP  = 3'd4;
   localparam logic [2:0] OP_CLR_CNT = 3'd5;

   localparam logic [2:0] CAUSE_RESET  = 3'd0;
   localparam logic [2:0] CAUSE_HOST   = 3'd1;
   localparam logic [2:0] CAUSE_STEP   = 3'd2;
   localparam logic [2:0] CAUSE_BP     = 3'd3;
   localparam logic [2:0] CAUSE_EBREAK = 3'd4;
   localparam logic [2:0] CAUSE_ECALL  = 3'd5;

   localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;

   logic [1:0]        state;
   logic              first;
   logic [STEP_W-1:0] step_cnt;
   logic [STEP_W-1:0] step_load;
   logic [31:0]       bp_addr [NUM_BP];
   logic [NUM_BP-1:0] bp_en;
   logic [NUM_BP-1:0] bp_vec;
   logic              bp_any;
   logic              is_ebreak;
   logic              is_ecall;
   logic              running;
   logic              stop_now;
   logic [2:0]        stop_cause;
   logic              step_last;
   logic              cmd_bad;
   logic              acc;
   logic              do_run, do_halt, do_step, do_set, do_clr, do_clr_cnt;

   assign cmd_ready = 1'b1;
   assign halted    = (state == ST_HALTED);

   // Breakpoint comparators; masked while the first instruction after a resume is pending.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
      bp_vec = '0;
      for (int i = 0; i < NUM_BP; i++) begin
         bp_vec[i] = bp_en[i] && (bp_addr[i] == pc) && !first;
      end
   end

   assign bp_any     = |bp_vec;
   assign is_ebreak  = (instr == INSTR_EBREAK);
   assign is_ecall   = (instr == INSTR_ECALL);
   assign running    = (state == ST_RUN) || (state == ST_STEP);
   assign stop_now   = running && (bp_any || is_ebreak || is_ecall);
   assign core_en    = running && !stop_now;
   assign stop_cause = bp_any ? CAUSE_BP : (is_ebreak ? CAUSE_EBREAK : CAUSE_ECALL);
   assign step_last  = (state == ST_STEP) && core_en && (step_cnt == STEP_W'(1));
   assign step_load  = (cmd_data[STEP_W-1:0] == '0) ? STEP_W'(1) : cmd_data[STEP_W-1:0];

   // Command legality check; an illegal command is reported and otherwise ignored.
   always_comb begin
      cmd_bad = 1'b0;
      case (cmd_op)
         OP_RUN, OP_STEP:      cmd_bad = running;
         OP_SET_BP, OP_CLR_BP: cmd_bad = (int'(cmd_idx) >= NUM_BP);
         OP_HALT, OP_CLR_CNT:  cmd_bad = 1'b0;
         default:              cmd_bad = 1'b1;
      endcase
   end

   assign acc        = cmd_valid && !cmd_bad;
   assign do_run     = acc && (cmd_op == OP_RUN);
   assign do_halt    = acc && (cmd_op == OP_HALT);
   assign do_step    = acc && (cmd_op == OP_STEP);
   assign do_set     = acc && (cmd_op == OP_SET_BP);
   assign do_clr     = acc && (cmd_op == OP_CLR_BP);
   assign do_clr_cnt = acc && (cmd_op == OP_CLR_CNT);

   // Run-control state machine: entry from HALTED, stop priority stop_now > step done > host halt.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state      <= ST_HALTED;
         halt_cause <= CAUSE_RESET;
         first      <= 1'b0;
         step_cnt   <= '0;
         bp_hit     <= '0;
      end else begin
         if (core_en) begin
            first <= 1'b0;
         end
         case (state)
            ST_HALTED: begin
               if (do_run) begin
                  state  <= ST_RUN;
                  first  <= 1'b1;
                  bp_hit <= '0;
               end else if (do_step) begin
                  state    <= ST_STEP;
                  first    <= 1'b1;
                  bp_hit   <= '0;
                  step_cnt <= step_load;
               end else if (do_halt) begin
                  halt_cause <= CAUSE_HOST;
               end
            end
            ST_RUN, ST_STEP: begin
               if ((state == ST_STEP) && core_en) begin
                  step_cnt <= step_cnt - STEP_W'(1);
               end
               if (stop_now) begin
                  state      <= ST_HALTED;
                  halt_cause <= stop_cause;
                  bp_hit     <= bp_hit | bp_vec;
                  step_cnt   <= '0;
               end else if (step_last) begin
                  state      <= ST_HALTED;
                  halt_cause <= CAUSE_STEP;
               end else if (do_halt) begin
                  state      <= ST_HALTED;
                  halt_cause <= CAUSE_HOST;
                  step_cnt   <= '0;
               end
            end
            default: begin
               state <= ST_HALTED;
            end
         endcase
      end
   end

   // Breakpoint address/enable registers, writable in any state.
   always_ff @(posedge clk) begin
      // NOTE: this small register array is reset explicitly because the host reads back a known disabled state; large RAMs would not be.
      if (rst) begin
         bp_en <= '0;
         for (int i = 0; i < NUM_BP; i++) begin
            bp_addr[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_BP; i++) begin
            if (int'(cmd_idx) == i) begin
               if (do_set) begin
                  bp_addr[i] <= cmd_data;
                  bp_en[i]   <= 1'b1;
               end else if (do_clr) begin
                  bp_en[i] <= 1'b0;
               end
            end
         end
      end
   end

   // Retired-instruction counter; a clear wins over a same-cycle increment.
   always_ff @(posedge clk) begin
      if (rst) begin
         retired <= '0;
      end else if (do_clr_cnt) begin
         retired <= '0;
      end else if (core_en) begin
         retired <= retired + CNT_W'(1);
      end
   end

   // Registered error pulse for the command seen in the previous cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_err <= 1'b0;
      end else begin
         cmd_err <= cmd_valid && cmd_bad;
      end
   end

endmodule

// File: tb/tb_core_run_ctrl.sv
// tb_core_run_ctrl: scoreboard bench for core_run_ctrl. Each scenario queues
// cycles together with the core_en and status expected for them, then plays
// the queue against the DUT.
module tb_core_run_ctrl;

   localparam int NUM_BP = 2;
   localparam int CNT_W  = 32;
   localparam int STEP_W = 16;

   localparam logic [31:0] ADDI   = 32'h0000_0013;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] ECALL  = 32'h0000_0073;

   localparam logic [2:0] OP_RUN     = 3'd0;
   localparam logic [2:0] OP_HALT    = 3'd1;
   localparam logic [2:0] OP_STEP    = 3'd2;
   localparam logic [2:0] OP_SET_BP  = 3'd3;
   localparam logic [2:0] OP_CLR_BP  = 3'd4;
   localparam logic [2:0] OP_CLR_CNT = 3'd5;

   typedef struct packed {
      logic        halted;
      logic [2:0]  cause;
      logic [31:0] retired;
      logic [1:0]  bp_hit;
      logic        err;
   } status_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        v;
      logic [2:0]  op;
      logic [1:0]  idx;
      logic [31:0] data;
      logic        rst;
      logic        en;
      logic        st_chk;
      status_t     st;
   } cycle_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [2:0]        cmd_op;
   logic [1:0]        cmd_idx;
   logic [31:0]       cmd_data;
   logic              cmd_err;
   logic [31:0]       pc;
   logic [31:0]       instr;
   logic              core_en;
   logic              halted;
   logic [2:0]        halt_cause;
   logic [NUM_BP-1:0] bp_hit;
   logic [CNT_W-1:0]  retired;

   cycle_t      stim_q[$];
   logic [31:0] exp_ret;
   int          checks;
   int          failures;

   always #5 clk = ~clk;

   core_run_ctrl #(.NUM_BP(NUM_BP), .CNT_W(CNT_W), .STEP_W(STEP_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_idx    (cmd_idx),
      .cmd_data   (cmd_data),
      .cmd_err    (cmd_err),
      .pc         (pc),
      .instr      (instr),
      .core_en    (core_en),
      .halted     (halted),
      .halt_cause (halt_cause),
      .bp_hit     (bp_hit),
      .retired    (retired)
   );

   // Queue one normal cycle with its expected core_en; expected retired is tracked here.
   task automatic cyc(input logic [31:0] p, input logic [31:0] ins, input logic v,
                      input logic [2:0] op, input logic [1:0] idx, input logic [31:0] d,
                      input logic en);
      cycle_t c;
      c.pc = p; c.instr = ins; c.v = v; c.op = op; c.idx = idx; c.data = d;
      c.rst = 1'b0; c.en = en; c.st_chk = 1'b0; c.st = '0;
      if (v && (op == OP_CLR_CNT)) exp_ret = 32'd0;
      else if (en) exp_ret = exp_ret + 32'd1;
      c.st.retired = exp_ret;
      stim_q.push_back(c);
   endtask

   // Queue one reset cycle; core_en in that cycle is not checked.
   task automatic rcyc(input logic [31:0] p);
      cycle_t c;
      c.pc = p; c.instr = ADDI; c.v = 1'b0; c.op = OP_RUN; c.idx = 2'd0; c.data = 32'd0;
      c.rst = 1'b1; c.en = 1'b0; c.st_chk = 1'b0; c.st = '0;
      exp_ret = 32'd0;
      c.st.retired = exp_ret;
      stim_q.push_back(c);
   endtask

   // Attach an expected post-edge status to the most recently queued cycle.
   task automatic st(input logic h, input logic [2:0] cause, input logic [1:0] bp, input logic err);
      cycle_t c;
      c = stim_q.pop_back();
      c.st_chk    = 1'b1;
      c.st.halted = h;
      c.st.cause  = cause;
      c.st.bp_hit = bp;
      c.st.err    = err;
      stim_q.push_back(c);
   endtask

   // Apply one cycle: core_en sampled mid-cycle, status sampled just after the edge.
   task automatic drive(input cycle_t c, output logic en, output status_t s);
      rst = c.rst; cmd_valid = c.v; cmd_op = c.op; cmd_idx = c.idx; cmd_data = c.data;
      pc = c.pc; instr = c.instr;
      @(negedge clk);
      en = core_en;
      @(posedge clk);
      #1;
      s = {halted, halt_cause, retired, bp_hit, cmd_err};
      cmd_valid = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      cycle_t c; logic en; status_t s;
      rcyc(32'h0);           st(1'b1, 3'd0, 2'b00, 1'b0);
      cyc(32'h0, ADDI, 1'b0, OP_RUN, 2'd0, 32'd0, 1'b0);
      while (stim_q.size() > 0) begin
         c = stim_q.pop_front();
         drive(c, en, s);
         if (!c.rst) begin
            checks++;
            if (en !== c.en) begin failures++; $display("FAIL reset core_en pc=%h got=%b exp=%b", c.pc, en, c.en); end
         end
         if (c.st_chk) begin
            checks++;
            if (s !== c.st) begin failures++; $display("FAIL reset status pc=%h got=%h exp=%h", c.pc, s, c.st); end
         end
      end
      checks++;
      if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset cmd_ready got=%b exp=1", cmd_ready); end
   endtask

   task automatic test_run();
      cycle_t c; logic en; status_t s;
      cyc(32'h0,  ADDI, 1'b1, OP_RUN,  2'd0, 32'd0, 1'b0); st(1'b0, 3'd0, 2'b00, 1'b0);
      cyc(32'h0,  ADDI, 1'b0, OP_RUN,  2'd0, 32'd0, 1'b1);
      cyc(32'h4,  ADDI, 1'b0, OP_RUN,  2'd0, 32'd0, 1'b1);
      cyc(32'h8,  ADDI, 1'b0, OP_RUN,  2'd0, 32'd0, 1'b1); st(1'b0, 3'd0, 2'b00, 1'b0);
      cyc(32'hc,  ADDI, 1'b1, OP_HALT, 2'd0, 32'd0, 1'b1); st(1'b1, 3'd1, 2'b00, 1'b0);
      cyc(32'h10, ADDI, 1'b0, OP_RUN,  2'd0, 32'd0, 1'b0); st(1'b1, 3'd1, 2'b00, 1'b0);
      while (stim_q.size() > 0) begin
         c = stim_q.pop_front();
         drive(c, en, s);
         if (!c.rst) begin
            checks++;
            if (en !== c.en) begin failures++; $display("FAIL run core_en pc=%h got=%b exp=%b", c.pc, en, c.en); end
         end
         if (c.st_chk) begin
            checks++;
            if (s !== c.st) begin failures++; $display("FAIL run status pc=%h got=%h exp=%h", c.pc, s, c.st); end
         end
      end
   endtask

   task automatic test_step();
      cycle_t c; logic en; status_t s;
      cyc(32'h100, ADDI, 1'b1, OP_STEP, 2'd0, 32'd2, 1'b0); st(1'b0, 3'd1, 2'b00, 1'b0);
      cyc(32'h100, ADDI, 1'b0, OP_RUN,  2'd0, 32'd0, 1'b1);
      cyc(32'h104, ADDI, 1'b0, OP_RUN,  2'd0, 32'd0, 1'b1); st(1'b1, 3'd2, 2'b00, 1'b0);
      cyc(32'h108, ADDI, 1'b0, OP_RUN,  2'd0, 32'd0, 1'b0);
      cyc(32'h108, ADDI, 1'b1, OP_STEP, 2'd0, 32'd0, 1'b0);
      cyc(32'h108, ADDI, 1'b0, OP_RUN,  2'd0, 32'd0, 1'b1); st(1'b1, 3'd2, 2'b00, 1'b0);
      cyc(32'h10c, ADDI, 1'b0, OP_RUN,  2'd0, 32'd0, 1'b0); st(1'b1, 3'd2, 2'b00, 1'b0);
      cyc(32'h10c, ADDI, 1'b1, OP_HALT, 2'd0, 32'd0, 1'b0); st(1'b1, 3'd1, 2'b00, 1'b0);
      while (stim_q.size() > 0) begin
         c = stim_q.pop_front();
         drive(c, en, s);
         if (!c.rst) begin
            checks++;
            if (en !== c.en) begin failures++; $display("FAIL step core_en pc=%h got=%b exp=%b", c.pc, en, c.en); end
         end
         if (c.st_chk) begin
            checks++;
            if (s !== c.st) begin failures++; $display("FAIL step status pc=%h got=%h exp=%h", c.pc, s, c.st); end
         end
      end
   endtask

   task automatic test_breakpoint();
      cycle_t c; logic en; status_t s;
      cyc(32'h0,  ADDI, 1'b1, OP_SET_BP, 2'd0, 32'h10, 1'b0);
      cyc(32'h0,  ADDI, 1'b1, OP_RUN,    2'd0, 32'd0,  1'b0);
      cyc(32'h0,  ADDI, 1'b0, OP_RUN,    2'd0, 32'd0,  1'b1);
      cyc(32'h4,  ADDI, 1'b0, OP_RUN,    2'd0, 32'd0,  1'b1);
      cyc(32'h8,  ADDI, 1'b0, OP_RUN,    2'd0, 32'd0,  1'b1);
      cyc(32'hc,  ADDI, 1'b0, OP_RUN,    2'd0, 32'd0,  1'b1);
      cyc(32'h10, ADDI, 1'b0, OP_RUN,    2'd0, 32'd0,  1'b0); st(1'b1, 3'd3, 2'b01, 1'b0);
      // Resume from the breakpoint PC executes that instruction.
      cyc(32'h10, ADDI, 1'b1, OP_RUN,    2'd0, 32'd0,  1'b0); st(1'b0, 3'd3, 2'b00, 1'b0);
      cyc(32'h10, ADDI, 1'b0, OP_RUN,    2'd0, 32'd0,  1'b1);
      cyc(32'h14, ADDI, 1'b0, OP_RUN,    2'd0, 32'd0,  1'b1);
      cyc(32'h18, ADDI, 1'b1, OP_HALT,   2'd0, 32'd0,  1'b1); st(1'b1, 3'd1, 2'b00, 1'b0);
      // Host halt coinciding with a match reports the breakpoint.
      cyc(32'h8,  ADDI, 1'b1, OP_RUN,    2'd0, 32'd0,  1'b0);
      cyc(32'hc,  ADDI, 1'b0, OP_RUN,    2'd0, 32'd0,  1'b1);
      cyc(32'h10, ADDI, 1'b1, OP_HALT,   2'd0, 32'd0,  1'b0); st(1'b1, 3'd3, 2'b01, 1'b0);
      // Cleared breakpoint no longer stops the core.
      cyc(32'h10, ADDI, 1'b1, OP_CLR_BP, 2'd0, 32'd0,  1'b0); st(1'b1, 3'd3, 2'b01, 1'b0);
      cyc(32'h10, ADDI, 1'b1, OP_RUN,    2'd0, 32'd0,  1'b0);
      cyc(32'h10, ADDI, 1'b0, OP_RUN,    2'd0, 32'd0,  1'b1);
      cyc(32'h10, ADDI, 1'b0, OP_RUN,    2'd0, 32'd0,  1'b1);
      cyc(32'h14, ADDI, 1'b1, OP_HALT,   2'd0, 32'd0,  1'b1); st(1'b1, 3'd1, 2'b00, 1'b0);
      while (stim_q.size() > 0) begin
         c = stim_q.pop_front();
         drive(c, en, s);
         if (!c.rst) begin
            checks++;
            if (en !== c.en) begin failures++; $display("FAIL breakpoint core_en pc=%h got=%b exp=%b", c.pc, en, c.en); end
         end
         if (c.st_chk) begin
            checks++;
            if (s !== c.st) begin failures++; $display("FAIL breakpoint status pc=%h got=%h exp=%h", c.pc, s, c.st); end
         end
      end
   endtask

   task automatic test_ebreak_ecall();
      cycle_t c; logic en; status_t s;
      cyc(32'h1c, ADDI,   1'b1, OP_RUN, 2'd0, 32'd0, 1'b0);
      cyc(32'h1c, ADDI,   1'b0, OP_RUN, 2'd0, 32'd0, 1'b1);
      cyc(32'h20, EBREAK, 1'b0, OP_RUN, 2'd0, 32'd0, 1'b0); st(1'b1, 3'd4, 2'b00, 1'b0);
      cyc(32'h20, EBREAK, 1'b1, OP_RUN, 2'd0, 32'd0, 1'b0);
      cyc(32'h20, EBREAK, 1'b0, OP_RUN, 2'd0, 32'd0, 1'b0); st(1'b1, 3'd4, 2'b00, 1'b0);
      cyc(32'h24, ECALL,  1'b1, OP_RUN, 2'd0, 32'd0, 1'b0);
      cyc(32'h24, ECALL,  1'b0, OP_RUN, 2'd0, 32'd0, 1'b0); st(1'b1, 3'd5, 2'b00, 1'b0);
      while (stim_q.size() > 0) begin
         c = stim_q.pop_front();
         drive(c, en, s);
         if (!c.rst) begin
            checks++;
            if (en !== c.en) begin failures++; $display("FAIL ebreak_ecall core_en pc=%h got=%b exp=%b", c.pc, en, c.en); end
         end
         if (c.st_chk) begin
            checks++;
            if (s !== c.st) begin failures++; $display("FAIL ebreak_ecall status pc=%h got=%h exp=%h", c.pc, s, c.st); end
         end
      end
   endtask

   task automatic test_errors();
      cycle_t c; logic en; status_t s;
      cyc(32'h40, ADDI, 1'b1, OP_RUN,     2'd0, 32'd0,  1'b0);
      cyc(32'h40, ADDI, 1'b1, OP_STEP,    2'd0, 32'd3,  1'b1); st(1'b0, 3'd5, 2'b00, 1'b1);
      cyc(32'h44, ADDI, 1'b0, OP_RUN,     2'd0, 32'd0,  1'b1); st(1'b0, 3'd5, 2'b00, 1'b0);
      cyc(32'h48, ADDI, 1'b1, OP_SET_BP,  2'd3, 32'h4c, 1'b1); st(1'b0, 3'd5, 2'b00, 1'b1);
      cyc(32'h4c, ADDI, 1'b0, OP_RUN,     2'd0, 32'd0,  1'b1); st(1'b0, 3'd5, 2'b00, 1'b0);
      cyc(32'h50, ADDI, 1'b1, 3'd6,       2'd0, 32'd0,  1'b1); st(1'b0, 3'd5, 2'b00, 1'b1);
      cyc(32'h54, ADDI, 1'b1, 3'd7,       2'd0, 32'd0,  1'b1); st(1'b0, 3'd5, 2'b00, 1'b1);
      // Counter clear wins over the same-cycle retire.
      cyc(32'h58, ADDI, 1'b1, OP_CLR_CNT, 2'd0, 32'd0,  1'b1); st(1'b0, 3'd5, 2'b00, 1'b0);
      cyc(32'h5c, ADDI, 1'b0, OP_RUN,     2'd0, 32'd0,  1'b1); st(1'b0, 3'd5, 2'b00, 1'b0);
      cyc(32'h60, ADDI, 1'b1, OP_HALT,    2'd0, 32'd0,  1'b1); st(1'b1, 3'd1, 2'b00, 1'b0);
      while (stim_q.size() > 0) begin
         c = stim_q.pop_front();
         drive(c, en, s);
         if (!c.rst) begin
            checks++;
            if (en !== c.en) begin failures++; $display("FAIL errors core_en pc=%h got=%b exp=%b", c.pc, en, c.en); end
         end
         if (c.st_chk) begin
            checks++;
            if (s !== c.st) begin failures++; $display("FAIL errors status pc=%h got=%h exp=%h", c.pc, s, c.st); end
         end
      end
   endtask

   task automatic test_reset_mid_step();
      cycle_t c; logic en; status_t s;
      // Breakpoint 1 ends a step early and discards the residual count.
      cyc(32'h60, ADDI, 1'b1, OP_SET_BP, 2'd1, 32'h68, 1'b0);
      cyc(32'h60, ADDI, 1'b1, OP_STEP,   2'd0, 32'd5,  1'b0);
      cyc(32'h60, ADDI, 1'b0, OP_RUN,    2'd0, 32'd0,  1'b1);
      cyc(32'h64, ADDI, 1'b0, OP_RUN,    2'd0, 32'd0,  1'b1);
      cyc(32'h68, ADDI, 1'b0, OP_RUN,    2'd0, 32'd0,  1'b0); st(1'b1, 3'd3, 2'b10, 1'b0);
      cyc(32'h68, ADDI, 1'b1, OP_STEP,   2'd0, 32'd5,  1'b0); st(1'b0, 3'd3, 2'b00, 1'b0);
      cyc(32'h68, ADDI, 1'b0, OP_RUN,    2'd0, 32'd0,  1'b1);
      rcyc(32'h6c);                                           st(1'b1, 3'd0, 2'b00, 1'b0);
      cyc(32'h6c, ADDI, 1'b0, OP_RUN,    2'd0, 32'd0,  1'b0);
      // Breakpoints are disabled by reset.
      cyc(32'h64, ADDI, 1'b1, OP_RUN,    2'd0, 32'd0,  1'b0);
      cyc(32'h64, ADDI, 1'b0, OP_RUN,    2'd0, 32'd0,  1'b1);
      cyc(32'h68, ADDI, 1'b0, OP_RUN,    2'd0, 32'd0,  1'b1);
      cyc(32'h6c, ADDI, 1'b1, OP_HALT,   2'd0, 32'd0,  1'b1); st(1'b1, 3'd1, 2'b00, 1'b0);
      while (stim_q.size() > 0) begin
         c = stim_q.pop_front();
         drive(c, en, s);
         if (!c.rst) begin
            checks++;
            if (en !== c.en) begin failures++; $display("FAIL reset_mid_step core_en pc=%h got=%b exp=%b", c.pc, en, c.en); end
         end
         if (c.st_chk) begin
            checks++;
            if (s !== c.st) begin failures++; $display("FAIL reset_mid_step status pc=%h got=%h exp=%h", c.pc, s, c.st); end
         end
      end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      exp_ret   = 32'd0;
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = OP_RUN;
      cmd_idx   = 2'd0;
      cmd_data  = 32'd0;
      pc        = 32'd0;
      instr     = ADDI;
      test_reset();
      test_run();
      test_step();
      test_breakpoint();
      test_ebreak_ecall();
      test_errors();
      test_reset_mid_step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
